// File: rtl/cache_pkg.sv
// Shared types and address-field positions for the two-way write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    localparam int WORD_BIT   = 2;
    localparam int IDX_LSB    = 3;
    localparam int TAG_LSB    = 9;
    localparam int ADDR_MSB   = 17;
    localparam int LINE_TAG_W = 10;

    typedef struct packed {
        logic                  valid;
        logic [LINE_TAG_W-1:0] tag;
        logic [63:0]           data;
    } line_t;

    function automatic logic [31:0] pick_word(input logic [63:0] block, input logic sel);
        return sel ? block[63:32] : block[31:0];
    endfunction

endpackage

// File: rtl/cache_set_array.sv
// Two-way line storage with per-set LRU bit: combinational lookup, synchronous fill/update.
module cache_set_array
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 10,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             word_sel_i,
    output logic             hit0_o,
    output logic             hit1_o,
    output logic [31:0]      word_o,
    output logic             lru_o,
    input  logic             fill_en_i,
    input  logic             fill_way_i,
    input  logic [63:0]      fill_data_i,
    input  logic             upd_en_i,
    input  logic             upd_way_i,
    input  logic [31:0]      upd_word_i,
    input  logic             lru_en_i,
    input  logic             lru_val_i
);

    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];

    line_t line0, line1;

    assign line0 = '{valid: valid_q[0][idx_i],
                     tag:   LINE_TAG_W'(tag_q[0][idx_i]),
                     data:  data_q[0][idx_i]};
    assign line1 = '{valid: valid_q[1][idx_i],
                     tag:   LINE_TAG_W'(tag_q[1][idx_i]),
                     data:  data_q[1][idx_i]};

    assign hit0_o = line0.valid && (line0.tag == LINE_TAG_W'(tag_i));
    assign hit1_o = line1.valid && (line1.tag == LINE_TAG_W'(tag_i));
    assign word_o = pick_word(hit1_o ? line1.data : line0.data, word_sel_i);
    assign lru_o  = lru_q[idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if (fill_en_i) valid_q[fill_way_i][idx_i] <= 1'b1;
            if (lru_en_i)  lru_q[idx_i]               <= lru_val_i;
        end
    end

    // NOTE: tag/data storage has no reset; the cleared valid bits alone decide whether a line is meaningful.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_way_i][idx_i]  <= tag_i;
            data_q[fill_way_i][idx_i] <= fill_data_i;
        end else if (upd_en_i) begin
            if (word_sel_i) data_q[upd_way_i][idx_i][63:32] <= upd_word_i;
            else            data_q[upd_way_i][idx_i][31:0]  <= upd_word_i;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between MEM stage and SRAM.
module cache_controller
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);

    state_e      state_q;
    logic [31:0] sram_address_q;
    logic [31:0] sram_wdata_q;
    logic        sram_r_en_q;
    logic        sram_w_en_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             word_sel;
    logic             hit0, hit1, hit, hit_way;
    logic [31:0]      hit_word;
    logic             lru_way;

    logic             fill_en, upd_en, lru_en, lru_val;

    assign idx      = address[IDX_LSB +: IDX_W];
    assign tag      = TAG_W'(address[ADDR_MSB:TAG_LSB]);
    assign word_sel = address[WORD_BIT];
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;

    cache_set_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_sets (
        .clk         (clk),
        .rst_n       (rst),
        .idx_i       (idx),
        .tag_i       (tag),
        .word_sel_i  (word_sel),
        .hit0_o      (hit0),
        .hit1_o      (hit1),
        .word_o      (hit_word),
        .lru_o       (lru_way),
        .fill_en_i   (fill_en),
        .fill_way_i  (lru_way),
        .fill_data_i (sram_rdata),
        .upd_en_i    (upd_en),
        .upd_way_i   (hit_way),
        .upd_word_i  (wdata),
        .lru_en_i    (lru_en),
        .lru_val_i   (lru_val)
    );

    // Read hits and SRAM completion must answer in the same cycle, so ready/rdata stay combinational.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        ready   = 1'b1;
        rdata   = '0;
        fill_en = 1'b0;
        upd_en  = 1'b0;
        lru_en  = 1'b0;
        lru_val = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready = 1'b0;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        rdata   = hit_word;
                        lru_en  = 1'b1;
                        lru_val = ~hit_way;
                    end else begin
                        ready = 1'b0;
                    end
                end
            end
            RD_MISS: begin
                ready = sram_ready;
                if (sram_ready) begin
                    rdata   = pick_word(sram_rdata, word_sel);
                    fill_en = 1'b1;
                    lru_en  = 1'b1;
                    lru_val = ~lru_way;
                end
            end
            WR_THRU: begin
                ready = sram_ready;
                if (sram_ready && hit) begin
                    upd_en  = 1'b1;
                    lru_en  = 1'b1;
                    lru_val = ~hit_way;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q        <= IDLE;
            sram_address_q <= '0;
            sram_wdata_q   <= '0;
            sram_r_en_q    <= 1'b0;
            sram_w_en_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state_q        <= WR_THRU;
                        sram_w_en_q    <= 1'b1;
                        sram_address_q <= address;
                        sram_wdata_q   <= wdata;
                    end else if (MEM_R_EN && !hit) begin
                        state_q        <= RD_MISS;
                        sram_r_en_q    <= 1'b1;
                        sram_address_q <= {address[31:3], 3'b000};
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        state_q     <= IDLE;
                        sram_r_en_q <= 1'b0;
                    end
                end
                WR_THRU: begin
                    if (sram_ready) begin
                        state_q     <= IDLE;
                        sram_w_en_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_address = sram_address_q;
    assign sram_wdata   = sram_wdata_q;
    assign sram_r_en    = sram_r_en_q;
    assign sram_w_en    = sram_w_en_q;

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench: the bench plays SRAM and predicts hits from an LRU model and data from a flat memory.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [2][64];
    int unsigned m_tag   [2][64];
    bit          m_lru   [64];
    logic [31:0] mem     [int unsigned];

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned f_idx(input logic [31:0] a);
        return (a >> 3) % 64;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] a);
        return (a >> 9) % 512;
    endfunction

    function automatic int model_way(input logic [31:0] a);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][f_idx(a)] && m_tag[w][f_idx(a)] == f_tag(a)) return w;
        return -1;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 64; s++) m_valid[w][s] = 1'b0;
        for (int s = 0; s < 64; s++) m_lru[s] = 1'b0;
    endtask

    task automatic idle_cycle(input bit stray_ready);
        sram_ready = stray_ready;
        sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        check("idle_ready", ready, 1);
        check("idle_ren", sram_r_en, 0);
        check("idle_wen", sram_w_en, 0);
        @(posedge clk);
        #1 sram_ready = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a);
        int          way;
        int          lat;
        int unsigned idx;
        bit          victim;
        logic [31:0] exp;
        logic [31:0] base;
        way  = model_way(a);
        exp  = mem_rd(a);
        base = {a[31:3], 3'b000};
        idx  = f_idx(a);
        address  = a;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        if (way >= 0) begin
            check("hit_ready", ready, 1);
            check("hit_rdata", rdata, exp);
            check("hit_ren", sram_r_en, 0);
            @(posedge clk);
            #1;
            m_lru[idx] = (way == 0);
        end else begin
            check("miss_ready", ready, 0);
            @(posedge clk);
            #1;
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                @(negedge clk);
                check("miss_wait_ready", ready, 0);
                check("miss_ren", sram_r_en, 1);
                check("miss_addr", sram_address, base);
                @(posedge clk);
                #1;
            end
            sram_rdata = {mem_rd(base + 32'd4), mem_rd(base)};
            sram_ready = 1'b1;
            @(negedge clk);
            check("fill_ready", ready, 1);
            check("fill_rdata", rdata, exp);
            check("fill_ren", sram_r_en, 1);
            check("fill_addr", sram_address, base);
            @(posedge clk);
            #1;
            sram_ready = 1'b0;
            victim = m_lru[idx];
            m_valid[victim][idx] = 1'b1;
            m_tag[victim][idx]   = f_tag(a);
            m_lru[idx]           = !victim;
        end
        MEM_R_EN = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int way;
        int lat;
        way = model_way(a);
        address  = a;
        wdata    = d;
        MEM_W_EN = 1'b1;
        MEM_R_EN = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("wr_ready", ready, 0);
        @(posedge clk);
        #1;
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            @(negedge clk);
            check("wr_wait_ready", ready, 0);
            check("wr_wen", sram_w_en, 1);
            check("wr_ren", sram_r_en, 0);
            check("wr_addr", sram_address, a);
            check("wr_data", sram_wdata, d);
            @(posedge clk);
            #1;
        end
        sram_ready = 1'b1;
        @(negedge clk);
        check("wr_done_ready", ready, 1);
        check("wr_done_wen", sram_w_en, 1);
        check("wr_done_addr", sram_address, a);
        check("wr_done_data", sram_wdata, d);
        @(posedge clk);
        #1;
        sram_ready = 1'b0;
        mem[a >> 2] = d;
        if (way >= 0) m_lru[f_idx(a)] = (way == 0);
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op;

        model_clear();
        mem[32'h10 >> 2] = 32'h1111_1111;
        mem[32'h14 >> 2] = 32'h2222_2222;

        #12;
        check("rst_ready", ready, 1);
        check("rst_ren", sram_r_en, 0);
        check("rst_wen", sram_w_en, 0);
        check("rst_rdata", rdata, 0);
        check("rst_saddr", sram_address, 0);
        check("rst_swdata", sram_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        do_load(32'h0000_0010);
        do_load(32'h0000_0014);

        do_load(32'h010);
        do_load(32'h210);
        do_load(32'h410);
        do_load(32'h010);
        do_load(32'h210);
        do_load(32'h610);
        do_load(32'h210);
        do_load(32'h010);

        do_store(32'h14, 32'hDEAD_BEEF);
        do_load(32'h14);

        do_store(32'h800, 32'hCAFE_F00D);
        do_load(32'h800);

        for (int i = 0; i < 300; i++) begin
            a  = ($urandom_range(0, 7) << 9) | ($urandom_range(0, 3) << 3)
               | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            if (op < 6)      do_load(a);
            else if (op < 9) do_store(a, $urandom);
            else             idle_cycle(1'($urandom_range(0, 1)));
        end

        do_load(32'h14);
        address  = 32'h0003_FE00;
        MEM_R_EN = 1'b1;
        @(negedge clk);
        check("abort_req_ready", ready, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_ren_before", sram_r_en, 1);
        #2;
        rst      = 1'b0;
        MEM_R_EN = 1'b0;
        #1;
        check("abort_ren", sram_r_en, 0);
        check("abort_ready", ready, 1);
        check("abort_wen", sram_w_en, 0);
        check("abort_saddr", sram_address, 0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
        do_load(32'h14);
        do_load(32'h14);
        idle_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache sitting between the MEM stage and the SRAM controller. It serves MEM-stage loads from on-chip tag/data arrays, fetches 64-bit blocks from SRAM on read misses, and forwards every store to SRAM. While a request is in flight it drives `ready` low, which freezes the pipeline.

## Interface

Parameters:
- SETS, 64: number of sets; index width is log2(SETS).
- TAG_W, 10: tag width; the address split must total 18 bits.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- address  in  32  byte address from MEM stage, already SRAM-offset-adjusted; bits [17:0] used
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load data
- ready  out  1  1 = request complete / no request; 0 = stall pipeline
- sram_address  out  32  address to SRAM controller
- sram_wdata  out  32  store data to SRAM controller
- sram_r_en  out  1  block read request
- sram_w_en  out  1  word write request
- sram_rdata  in  64  fetched block; word 0 in [31:0]
- sram_ready  in  1  SRAM controller done (one-cycle pulse)

## Operation

- Address split: [1:0] byte (ignored), [2] word select, [8:3] index, [17:9] tag (9 bits used, zero-extended to TAG_W).
- Per set and way: valid bit, tag, 64-bit data. Per set: 1 LRU bit naming the way to replace.
- Hit: valid && tag match in a way. A hit in way w sets LRU[index] = ~w.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - Read hit: rdata = selected word, ready = 1, no SRAM activity, stay IDLE.
  - Read miss: ready = 0, go RD_MISS.
  - Write: ready = 0, go WR_THRU.
  - If both enables are high, the request is treated as a write.
- RD_MISS:
  - sram_r_en = 1, sram_address = {address[31:3],3'b000}.
  - On sram_ready: write the block into way LRU[index] with valid = 1 and the new tag, set LRU[index] = ~victim, drive rdata from the sram_rdata word selected by address[2], set ready = 1, go IDLE.
- WR_THRU:
  - sram_w_en = 1, sram_address = address, sram_wdata = wdata.
  - On sram_ready: if the address hits, update only the addressed word in the hitting way and update LRU; a miss does not allocate. Set ready = 1, go IDLE.
- No request: ready = 1, SRAM enables low.

## Timing

- Reset (asynchronous, rst = 0): state = IDLE, all valid bits = 0, all LRU bits = 0. Outputs: ready = 1, sram_r_en = 0, sram_w_en = 0, rdata = 0, sram_address = 0, sram_wdata = 0.
- Read hit: 0 stall cycles; rdata and ready are combinational from the registered arrays in the request cycle.
- Read miss: ready is low from the request cycle until the sram_ready cycle, inclusive of N SRAM cycles. ready = 1 in the sram_ready cycle. The next request is accepted on the following cycle.
- Write: the same stall pattern as a read miss.
- SRAM enables are held stable until sram_ready; sram_ready is ignored in IDLE.
- The MEM-stage request must stay stable while ready = 0; the pipeline freeze guarantees this.
- A reset during RD_MISS or WR_THRU aborts the access: no array update, state returns to IDLE.
- A read of a line that was just filled hits on the next access.

## Structure

- Package cache_pkg holds:
  - the state enum (IDLE, RD_MISS, WR_THRU)
  - address field constants (WORD_BIT = 2, IDX_LSB = 3, TAG_LSB = 9)
  - a line struct {valid, tag, data[63:0]}
- Sub-module cache_set_array:
  - two ways of line storage plus the LRU bits, with asynchronous clear of valid/LRU
  - provides combinational lookup (hit0, hit1, selected word)
  - provides synchronous fill / word-update / LRU-update ports
- cache_controller holds the FSM and the output muxing.

## Test plan

- Reset, then load 0x0000_0010 → ready drops, sram_r_en = 1 with sram_address = 0x10. When sram_ready returns sram_rdata = 0x2222_2222_1111_1111, rdata = 0x1111_1111 and ready = 1.
- Immediately load 0x0000_0014 → hit, ready = 1 in the same cycle, rdata = 0x2222_2222, no sram_r_en.
- Fill 0x010, 0x210 and 0x410 (same index, different tags), then load 0x010 → the miss evicts via LRU. Verify 0x210 hits and 0x010 re-misses after 0x610 is loaded.
- Store 0xDEAD_BEEF to cached 0x14 → sram_w_en = 1, sram_wdata = 0xDEAD_BEEF. After sram_ready, load 0x14 hits with 0xDEAD_BEEF.
- Store to uncached 0x800 → write-through only; a subsequent load of 0x800 misses.
- Assert rst mid-RD_MISS → sram_r_en drops immediately, ready = 1, and the prior hit address now misses.
